// File: rtl/crypto1_pkg.sv
// Shared types and sizes for the Crypto1 key-search job scheduler.
package crypto1_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StAborting,
        StFinish
    } state_t;

    // 16 even x 16 odd subspaces
    localparam int unsigned NJOBS = 256;
    localparam int unsigned IDX_W = 8;
    localparam int unsigned KEY_W = 48;
    // Wide enough to hold NJOBS itself
    localparam int unsigned CNT_W = 9;

endpackage

// File: rtl/crypto1_prio_pick.sv
// Lowest-set-bit one-hot picker.
module crypto1_prio_pick #(
    parameter int unsigned WIDTH = 4
) (
    input  logic [WIDTH-1:0] i_req,
    output logic [WIDTH-1:0] o_gnt
);

    logic w_taken;

    // Grant the lowest-index requester only
    always_comb begin
        o_gnt   = '0;
        w_taken = 1'b0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            if (i_req[i] && !w_taken) begin
                o_gnt[i] = 1'b1;
                w_taken  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/crypto1_job_scheduler.sv
// Hands out the 256 Crypto1 key subspaces to a pool of search cores, counts
// completions, and stops everything on the first key hit.
module crypto1_job_scheduler
    import crypto1_pkg::*;
#(
    parameter int unsigned NCORES = 4
) (
    input  logic                    CLK,
    input  logic                    RESETn,
    input  logic                    i_start,
    input  logic [KEY_W-1:0]        i_bitstream,
    output logic                    o_busy,
    output logic                    o_done,
    output logic                    o_found,
    output logic [KEY_W-1:0]        o_key,
    output logic [CNT_W-1:0]        o_jobs_done,
    output logic [KEY_W-1:0]        o_core_bitstream,
    output logic [NCORES-1:0]       o_job_valid,
    input  logic [NCORES-1:0]       i_job_ready,
    output logic [IDX_W-1:0]        o_job_idx,
    input  logic [NCORES-1:0]       i_core_done,
    input  logic [NCORES-1:0]       i_core_hit,
    input  logic [NCORES*KEY_W-1:0] i_core_key,
    output logic                    o_abort
);

    localparam logic [CNT_W-1:0] LP_NJOBS   = CNT_W'(NJOBS);
    localparam logic [CNT_W:0]   LP_NJOBS_W = (CNT_W+1)'(NJOBS);

    function automatic logic [4:0] f_popcount(input logic [NCORES-1:0] v);
        logic [4:0] cnt;
        cnt = '0;
        for (int i = 0; i < int'(NCORES); i++) begin
            cnt = cnt + {4'b0, v[i]};
        end
        return cnt;
    endfunction

    state_t             r_state, w_state_d;
    logic [CNT_W-1:0]   r_next_job, w_next_job_d;
    logic [CNT_W-1:0]   r_jobs_done, w_jobs_done_d;
    logic               r_found, w_found_d;
    logic [KEY_W-1:0]   r_key, w_key_d;
    logic [KEY_W-1:0]   r_bitstream, w_bitstream_d;
    logic [NCORES-1:0]  r_job_valid, w_job_valid_d;
    logic [IDX_W-1:0]   r_job_idx, w_job_idx_d;

    logic               w_xfer;
    logic               w_offer;
    logic [NCORES-1:0]  w_free_req, w_free_gnt;
    logic [NCORES-1:0]  w_hit_req, w_hit_gnt;
    logic [KEY_W-1:0]   w_hit_key;
    logic [CNT_W:0]     w_done_sum;
    logic [CNT_W-1:0]   w_done_sat;
    logic               w_all_done;

    assign w_xfer     = |(r_job_valid & i_job_ready);
    // The core taking a job this cycle is no longer free for the next offer
    assign w_free_req = i_job_ready & ~(r_job_valid & i_job_ready);
    assign w_hit_req  = i_core_done & i_core_hit;
    assign w_done_sum = {1'b0, r_jobs_done} + {{(CNT_W-4){1'b0}}, f_popcount(i_core_done)};
    assign w_all_done = (w_done_sum >= LP_NJOBS_W);
    assign w_done_sat = w_all_done ? LP_NJOBS : w_done_sum[CNT_W-1:0];

    crypto1_prio_pick #(
        .WIDTH (NCORES)
    ) u_free_pick (
        .i_req (w_free_req),
        .o_gnt (w_free_gnt)
    );

    crypto1_prio_pick #(
        .WIDTH (NCORES)
    ) u_hit_pick (
        .i_req (w_hit_req),
        .o_gnt (w_hit_gnt)
    );

    // Select the key of the lowest-index hitting core
    always_comb begin
        w_hit_key = '0;
        for (int i = 0; i < int'(NCORES); i++) begin
            if (w_hit_gnt[i]) begin
                w_hit_key = w_hit_key | i_core_key[KEY_W*i +: KEY_W];
            end
        end
    end

    // Next-state, dispatch and completion accounting
    always_comb begin
        w_state_d     = r_state;
        w_next_job_d  = r_next_job;
        w_jobs_done_d = r_jobs_done;
        w_found_d     = r_found;
        w_key_d       = r_key;
        w_bitstream_d = r_bitstream;
        w_offer       = 1'b0;

        unique case (r_state)
            StIdle: begin
                if (i_start) begin
                    w_state_d     = StRun;
                    w_bitstream_d = i_bitstream;
                    w_next_job_d  = '0;
                    w_jobs_done_d = '0;
                    w_found_d     = 1'b0;
                    w_key_d       = '0;
                    w_offer       = 1'b1;
                end
            end
            StRun: begin
                if (w_xfer) begin
                    w_next_job_d = r_next_job + CNT_W'(1);
                end
                w_jobs_done_d = w_done_sat;
                if (|w_hit_req) begin
                    w_found_d = 1'b1;
                    w_key_d   = w_hit_key;
                    w_state_d = StAborting;
                end else if (w_all_done) begin
                    w_state_d = StFinish;
                end else begin
                    w_offer = 1'b1;
                end
            end
            StAborting: begin
                // Late completions still count; their hits do not
                w_jobs_done_d = w_done_sat;
                w_state_d     = StFinish;
            end
            StFinish: begin
                w_state_d = StIdle;
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase

        w_job_valid_d = (w_offer && (w_next_job_d < LP_NJOBS)) ? w_free_gnt : '0;
        w_job_idx_d   = w_next_job_d[IDX_W-1:0];
    end

    // State and output registers
    always_ff @(posedge CLK) begin
        if (!RESETn) begin
            r_state     <= StIdle;
            r_next_job  <= '0;
            r_jobs_done <= '0;
            r_found     <= 1'b0;
            r_key       <= '0;
            r_bitstream <= '0;
            r_job_valid <= '0;
            r_job_idx   <= '0;
        end else begin
            r_state     <= w_state_d;
            r_next_job  <= w_next_job_d;
            r_jobs_done <= w_jobs_done_d;
            r_found     <= w_found_d;
            r_key       <= w_key_d;
            r_bitstream <= w_bitstream_d;
            r_job_valid <= w_job_valid_d;
            r_job_idx   <= w_job_idx_d;
        end
    end

    assign o_busy           = (r_state != StIdle);
    assign o_done           = (r_state == StFinish);
    assign o_abort          = (r_state == StAborting);
    assign o_found          = r_found;
    assign o_key            = r_key;
    assign o_jobs_done      = r_jobs_done;
    assign o_core_bitstream = r_bitstream;
    assign o_job_valid      = r_job_valid;
    assign o_job_idx        = r_job_idx;

endmodule

// File: tb/tb_crypto1_job_scheduler.sv
// Bench for crypto1_job_scheduler: behavioural stub cores plus a cycle-level
// reference model of the scheduler's externally visible behaviour.
module tb_crypto1_job_scheduler;

    localparam int NC  = 4;
    localparam int BIG = 1 << 30;

    logic              CLK = 1'b0;
    logic              RESETn = 1'b0;
    logic              i_start = 1'b0;
    logic [47:0]       i_bitstream = '0;
    logic              o_busy, o_done, o_found, o_abort;
    logic [47:0]       o_key, o_core_bitstream;
    logic [8:0]        o_jobs_done;
    logic [NC-1:0]     o_job_valid;
    logic [NC-1:0]     i_job_ready = '0;
    logic [7:0]        o_job_idx;
    logic [NC-1:0]     i_core_done = '0;
    logic [NC-1:0]     i_core_hit = '0;
    logic [NC*48-1:0]  i_core_key = '0;

    always #5 CLK = ~CLK;

    crypto1_job_scheduler #(
        .NCORES (NC)
    ) dut (
        .CLK              (CLK),
        .RESETn           (RESETn),
        .i_start          (i_start),
        .i_bitstream      (i_bitstream),
        .o_busy           (o_busy),
        .o_done           (o_done),
        .o_found          (o_found),
        .o_key            (o_key),
        .o_jobs_done      (o_jobs_done),
        .o_core_bitstream (o_core_bitstream),
        .o_job_valid      (o_job_valid),
        .i_job_ready      (i_job_ready),
        .o_job_idx        (o_job_idx),
        .i_core_done      (i_core_done),
        .i_core_hit       (i_core_hit),
        .i_core_key       (i_core_key),
        .o_abort          (o_abort)
    );

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Stub core state and configuration
    bit          s_busy [NC];
    int          s_cnt  [NC];
    int          s_job  [NC];
    bit          s_en   [NC];
    logic [47:0] keys   [NC];
    int          core_jobs [NC];
    int          lat_min = 3, lat_max = 3;
    bit          rnd_ready = 0;
    int          hit_job = -1;
    logic [NC-1:0] inj_done = '0, inj_hit = '0;

    // Reference model
    bit          m_started = 0;
    bit          m_running = 0;
    int          m_run_from = 0, m_end = -10, m_hit_cyc = -10;
    int          m_count = 0, m_next_job = 0;
    bit          m_found = 0;
    logic [47:0] m_key = '0, m_bs = '0;
    int          disp_cnt [256];
    logic [NC-1:0] ready_prev = '0, xfer_prev = '0;
    bit          rst_prev = 1;
    bit          want_start = 0;

    function automatic logic [NC-1:0] lowest(input logic [NC-1:0] v);
        for (int i = 0; i < NC; i++) if (v[i]) return NC'(1) << i;
        return '0;
    endfunction

    function automatic bit busy_exp(input int n);
        return m_started && n >= m_run_from && n <= m_end;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic check_outputs();
        logic [NC-1:0] ev;
        ev = '0;
        chk("busy", 64'(o_busy), 64'(busy_exp(cyc)));
        chk("done", 64'(o_done), 64'(m_started && cyc == m_end));
        chk("abort", 64'(o_abort), 64'(m_hit_cyc >= 0 && cyc == m_hit_cyc + 1));
        chk("found", 64'(o_found), 64'(m_found));
        chk("key", 64'(o_key), 64'(m_key));
        chk("jobs_done", 64'(o_jobs_done), 64'(m_count));
        chk("core_bitstream", 64'(o_core_bitstream), 64'(m_bs));
        if (m_running && m_next_job < 256) ev = lowest(ready_prev & ~xfer_prev);
        chk("job_valid", 64'(o_job_valid), 64'(ev));
        if (ev != '0) chk("job_idx", 64'(o_job_idx), 64'(m_next_job[7:0]));
        if (rst_prev) chk("rst_job_idx", 64'(o_job_idx), 64'd0);
        rst_prev = 0;
    endtask

    task automatic model_reset();
        m_started = 0; m_running = 0; m_end = -10; m_hit_cyc = -10;
        m_count = 0; m_next_job = 0; m_found = 0; m_key = '0; m_bs = '0;
        ready_prev = '0; xfer_prev = '0;
    endtask

    // One clock cycle: check outputs, run the stubs, drive inputs, update model.
    task automatic tick(input bit rst);
        logic [NC-1:0]    d_done, d_hit, d_ready, xfer, hits;
        logic [NC*48-1:0] d_key;
        logic [47:0]      bs;
        int               pc;
        cyc++;
        check_outputs();
        bs = {16'($urandom), $urandom};
        if (rst) begin
            RESETn = 1'b0; i_start = 1'b0; i_bitstream = bs;
            i_job_ready = '0; i_core_done = '0; i_core_hit = '0;
            for (int c = 0; c < NC; c++) s_busy[c] = 0;
            inj_done = '0; inj_hit = '0;
            model_reset();
            rst_prev = 1;
            @(negedge CLK);
            return;
        end
        RESETn = 1'b1;
        d_done = '0; d_hit = '0; d_key = '0;
        for (int c = 0; c < NC; c++) begin
            if (s_busy[c]) begin
                s_cnt[c]--;
                if (s_cnt[c] == 0) begin
                    d_done[c] = 1'b1;
                    d_hit[c]  = (s_job[c] == hit_job);
                    s_busy[c] = 0;
                end
            end
            if (inj_done[c]) begin
                d_done[c] = 1'b1;
                d_hit[c]  = inj_hit[c];
            end
            d_key[48*c +: 48] = keys[c];
        end
        inj_done = '0; inj_hit = '0;
        if (o_abort) for (int c = 0; c < NC; c++) s_busy[c] = 0;
        for (int c = 0; c < NC; c++)
            d_ready[c] = s_en[c] && !s_busy[c] && (!rnd_ready || $urandom_range(3, 0) != 0);
        xfer = o_job_valid & d_ready;
        for (int c = 0; c < NC; c++) begin
            if (xfer[c]) begin
                chk("xfer_idx", 64'(o_job_idx), 64'(m_next_job[7:0]));
                disp_cnt[o_job_idx]++;
                core_jobs[c]++;
                m_next_job++;
                s_busy[c] = 1;
                s_job[c]  = int'(o_job_idx);
                s_cnt[c]  = int'($urandom_range(lat_max, lat_min));
            end
        end
        i_job_ready = d_ready; i_core_done = d_done; i_core_hit = d_hit;
        i_core_key = d_key; i_bitstream = bs; i_start = want_start;
        // Completions count in RUN and in the single abort cycle
        pc = 0;
        for (int c = 0; c < NC; c++) pc += int'(d_done[c]);
        if (m_running || (m_hit_cyc >= 0 && cyc == m_hit_cyc + 1)) m_count += pc;
        if (m_running) begin
            hits = d_done & d_hit;
            if (hits != '0) begin
                m_hit_cyc = cyc; m_end = cyc + 2; m_found = 1; m_running = 0;
                for (int c = NC - 1; c >= 0; c--) if (hits[c]) m_key = keys[c];
            end else if (m_count >= 256) begin
                m_end = cyc + 1; m_running = 0;
            end
        end
        if (want_start && !busy_exp(cyc)) begin
            m_started = 1; m_running = 1; m_run_from = cyc + 1; m_end = BIG;
            m_hit_cyc = -10; m_count = 0; m_next_job = 0; m_found = 0;
            m_key = '0; m_bs = bs;
            for (int j = 0; j < 256; j++) disp_cnt[j] = 0;
            for (int c = 0; c < NC; c++) core_jobs[c] = 0;
        end
        want_start = 0;
        ready_prev = d_ready; xfer_prev = xfer;
        @(negedge CLK);
    endtask

    task automatic cfg(input int lmin, input int lmax, input bit en0, input bit rnd,
                       input int hj);
        lat_min = lmin; lat_max = lmax; rnd_ready = rnd; hit_job = hj;
        for (int c = 0; c < NC; c++) begin
            s_en[c] = (c == 0) ? en0 : 1'b1;
            keys[c] = {16'($urandom), $urandom};
        end
    endtask

    task automatic run_until_idle(input int budget);
        int k;
        k = 0;
        while (k < budget && (want_start || m_running || cyc <= m_end)) begin
            tick(0);
            k++;
        end
        chk("end_idle", 64'(o_busy), 64'd0);
    endtask

    task automatic chk_disp_once(input string tag);
        int bad;
        bad = 0;
        for (int j = 0; j < 256; j++) if (disp_cnt[j] != 1) bad++;
        chk(tag, 64'(bad), 64'd0);
    endtask

    initial begin
        for (int c = 0; c < NC; c++) begin
            s_busy[c] = 0; s_cnt[c] = 0; s_job[c] = -1; core_jobs[c] = 0;
        end
        for (int j = 0; j < 256; j++) disp_cnt[j] = 0;
        cfg(3, 3, 1, 0, -1);
        @(negedge CLK);
        repeat (3) tick(1);
        tick(0);

        // Full search, no hit
        want_start = 1;
        run_until_idle(2000);
        chk("t1_jobs_done", 64'(o_jobs_done), 64'd256);
        chk("t1_found", 64'(o_found), 64'd0);
        chk_disp_once("t1_disp_once");

        // Single hit from core 2 on subspace 0x5A
        cfg(3, 3, 1, 0, 'h5A);
        keys[2] = 48'hA0A1A2A3A4A5;
        want_start = 1;
        run_until_idle(2000);
        chk("t2_found", 64'(o_found), 64'd1);
        chk("t2_key", 64'(o_key), 64'hA0A1A2A3A4A5);

        // Cores 1 and 3 hit together: lower index wins
        cfg(3, 3, 1, 0, -1);
        want_start = 1;
        repeat (20) tick(0);
        inj_done = 4'b1010; inj_hit = 4'b1010;
        run_until_idle(2000);
        chk("t3_found", 64'(o_found), 64'd1);
        chk("t3_key", 64'(o_key), 64'(keys[1]));

        // Core 0 never ready, random readiness and latency elsewhere
        cfg(1, 5, 0, 1, -1);
        want_start = 1;
        run_until_idle(6000);
        chk("t4_core0_jobs", 64'(core_jobs[0]), 64'd0);
        chk("t4_jobs_done", 64'(o_jobs_done), 64'd256);
        chk_disp_once("t4_disp_once");

        // Second START ignored, then reset mid-search, then clean restart
        cfg(3, 3, 1, 0, -1);
        want_start = 1;
        repeat (10) tick(0);
        want_start = 1;
        for (int k = 0; k < 600 && o_jobs_done < 9'd100; k++) tick(0);
        chk("t5_jobs100", 64'(o_jobs_done), 64'd100);
        tick(1);
        tick(0);
        want_start = 1;
        run_until_idle(2000);
        chk_disp_once("t5_disp_once");

        // Hit on the 256th completion
        cfg(3, 3, 1, 0, 255);
        want_start = 1;
        run_until_idle(2000);
        chk("t6_found", 64'(o_found), 64'd1);
        chk("t6_jobs_done", 64'(o_jobs_done), 64'd256);
        chk("t6_key", 64'(o_key), 64'(keys[3]));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/crypto1_job_scheduler.md
# crypto1_job_scheduler

Distributes the 256 Crypto1 key subspaces (even index 0-15 × odd index 0-15) across a pool of NCORES search cores, all sharing one latched 48-bit bitstream. Tracks outstanding jobs, stops the search on the first key hit, aborts all cores, and reports the recovered key. Sits between the host/bus register block and the array of runtime-indexed Crypto1 search cores.

## Interface
- NCORES, 4: number of search cores, 1-16.
- NJOBS, 256: number of subspaces; fixed by the even/odd split.
- CLK  in  1  clock
- RESETn  in  1  reset, synchronous, active-low
- START  in  1  one-cycle pulse; begins a search; ignored unless IDLE
- BITSTREAM  in  48  keystream bits; sampled on the START cycle
- BUSY  out  1  search in progress
- DONE  out  1  one-cycle pulse at end of search
- FOUND  out  1  valid with DONE, held until next START; key recovered
- KEY  out  48  recovered key; held until next START
- JOBS_DONE  out  9  completed-subspace count, 0-256
- CORE_BITSTREAM  out  48  latched bitstream, broadcast to all cores
- JOB_VALID  out  NCORES  one-hot job offer
- JOB_READY  in  NCORES  core idle and able to accept a job
- JOB_IDX  out  8  offered subspace; [7:4] even index, [3:0] odd index
- CORE_DONE  in  NCORES  one-cycle pulse per core when its subspace finishes
- CORE_HIT  in  NCORES  qualifies CORE_DONE; key found
- CORE_KEY  in  NCORES*48  per-core key, valid with CORE_HIT; core i at [48*i+47:48*i]
- ABORT  out  1  one-cycle pulse; all cores drop their current job

## Operation
- States: IDLE, RUN, ABORTING, FINISH.
- IDLE, START=1:
  - latch BITSTREAM into CORE_BITSTREAM;
  - clear next_job (9 b), JOBS_DONE, FOUND, KEY;
  - go to RUN.
- RUN, dispatch:
  - While next_job < NJOBS, offer next_job to the lowest-index core with JOB_READY=1.
  - JOB_VALID is at most one-hot. JOB_IDX and the target core are held stable until JOB_READY is high in the same cycle; that cycle is the transfer.
  - On transfer, next_job increments by 1. At most one dispatch per cycle.
  - If the target core drops JOB_READY before a transfer, re-arbitrate next cycle.
- RUN, completion:
  - Each cycle, JOBS_DONE += popcount(CORE_DONE).
  - If any CORE_DONE&CORE_HIT: latch CORE_KEY of the lowest-index hitting core, set FOUND, go to ABORTING.
  - Else if JOBS_DONE reaches 256 (counting this cycle's completions): go to FINISH.
- ABORTING:
  - ABORT=1 and JOB_VALID=0 for exactly one cycle, then go to FINISH.
  - CORE_DONE arriving in this cycle is counted; its hits are ignored.
- FINISH: DONE=1 for one cycle, then go to IDLE.
- Simultaneous events:
  - A hit in the same cycle as a transfer: the transfer counts, then ABORT cancels it.
  - A hit in the same cycle as the 256th completion: FOUND=1, ABORTING path.
- Other boundaries:
  - START outside IDLE is ignored.
  - CORE_DONE in IDLE or FINISH is ignored.
  - next_job saturates at 256; no offers afterwards.
- Reset mid-search: state goes to IDLE, all outputs to reset values, in-flight core results discarded. Cores reset on the same RESETn.

## Timing
- Reset values: BUSY, DONE, FOUND, ABORT, JOB_VALID = 0; KEY, JOBS_DONE, JOB_IDX, CORE_BITSTREAM = 0.
- START at cycle T: CORE_BITSTREAM valid, BUSY=1, and the first JOB_VALID with JOB_IDX=0 all at T+1.
- With all cores ready, jobs 0..NCORES-1 transfer in cycles T+1..T+NCORES.
- Hit on CORE_DONE at cycle H:
  - FOUND, KEY, ABORT at H+1;
  - DONE at H+2;
  - BUSY low from H+3.
- Last completion, no hit, at cycle L: DONE at L+1, BUSY low from L+2.
- All registered outputs; no combinational path from core inputs to outputs.

## Structure
- Package crypto1_pkg holds:
  - state_t enum;
  - localparams NJOBS=256, IDX_W=8, KEY_W=48, CNT_W=9.
- Sub-module crypto1_prio_pick: parameterised lowest-set-bit one-hot picker, instanced twice (free-core select, hit select).
- The popcount is a local function.

## Test plan
- NCORES=4; stub cores that are always ready, finish in 3 cycles, never hit; START -> JOB_IDX 0..255 each dispatched exactly once, JOBS_DONE=256, DONE with FOUND=0.
- Stub core 2 hits on JOB_IDX 0x5A with key 0xA0A1A2A3A4A5 -> KEY=0xA0A1A2A3A4A5, FOUND=1, ABORT one cycle before DONE, no JOB_VALID after the hit.
- Cores 1 and 3 hit in the same cycle with different keys -> KEY equals core 1's key.
- Core 0 holds JOB_READY=0 throughout -> no transfer ever targets core 0; all 256 jobs complete on cores 1-3.
- START pulsed again mid-search, then RESETn low for one cycle at JOBS_DONE=100 -> second START ignored; after reset all outputs are 0 and a new START restarts at JOB_IDX 0.
- Hit arrives in the same cycle as the 256th completion -> FOUND=1, DONE two cycles later.
